// File: rtl/sd_sector_dma.sv
// Single-sector (CMD17) reader: drives the sdcard SPI byte engine one op at a time and
// streams the 512 data bytes into shared RAM through a req/gnt write port.
module sd_sector_dma #(
    parameter int unsigned R1_TRIES    = 16,
    parameter int unsigned TOKEN_TRIES = 4096
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic [31:0] lba_i,
    input  logic        sdhc_i,
    input  logic [15:0] base_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  error_o,
    output logic        spi_sent_o,
    output logic [1:0]  spi_cmd_o,
    output logic [7:0]  spi_out_o,
    input  logic [7:0]  spi_din_i,
    input  logic [1:0]  spi_st_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_data_o,
    input  logic        mem_gnt_i
);

    localparam logic [1:0] CmdXfer   = 2'd0;
    localparam logic [1:0] CmdCsLow  = 2'd2;
    localparam logic [1:0] CmdCsHigh = 2'd3;

    localparam logic [2:0] ErrOk     = 3'd0;
    localparam logic [2:0] ErrSpi    = 3'd1;
    localparam logic [2:0] ErrR1Tmo  = 3'd2;
    localparam logic [2:0] ErrR1Bad  = 3'd3;
    localparam logic [2:0] ErrTokTmo = 3'd4;
    localparam logic [2:0] ErrTokBad = 3'd5;

    localparam logic [12:0] R1Max  = 13'(R1_TRIES);
    localparam logic [12:0] TokMax = 13'(TOKEN_TRIES);

    typedef enum logic [3:0] {
        StIdle,
        StCsLo,
        StCmd,
        StR1,
        StToken,
        StData,
        StMemWr,
        StCrc,
        StCsHi,
        StTrail,
        StFin
    } state_e;

    // Phases of one SPI op: strobe out, strobe visible, ignore-status cycle, poll busy.
    typedef enum logic [1:0] {
        PhIssue,
        PhSent,
        PhGap,
        PhPoll
    } phase_e;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [12:0] cnt_q, cnt_d;
    logic [31:0] arg_q, arg_d;
    logic [15:0] base_q, base_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  error_q, error_d;
    logic        spi_sent_q, spi_sent_d;
    logic [1:0]  spi_cmd_q, spi_cmd_d;
    logic [7:0]  spi_out_q, spi_out_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_data_q, mem_data_d;

    logic        op_active;
    logic        op_done;
    logic        in_tail;
    logic [1:0]  op_cmd;
    logic [7:0]  op_byte;
    logic [7:0]  cmd_byte;

    assign op_active = (state_q != StIdle) && (state_q != StMemWr) && (state_q != StFin);
    assign op_done   = op_active && (phase_q == PhPoll) && !spi_st_i[0];
    assign in_tail   = (state_q == StCsHi) || (state_q == StTrail);

    always_comb begin
        cmd_byte = 8'hFF;
        case (cnt_q[2:0])
            3'd0:    cmd_byte = 8'h51;
            3'd1:    cmd_byte = arg_q[31:24];
            3'd2:    cmd_byte = arg_q[23:16];
            3'd3:    cmd_byte = arg_q[15:8];
            3'd4:    cmd_byte = arg_q[7:0];
            default: cmd_byte = 8'hFF;
        endcase
    end

    always_comb begin
        op_cmd  = CmdXfer;
        op_byte = 8'hFF;
        case (state_q)
            StCsLo:  op_cmd = CmdCsLow;
            StCsHi:  op_cmd = CmdCsHigh;
            StCmd:   op_byte = cmd_byte;
            default: op_cmd = CmdXfer;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        arg_d      = arg_q;
        base_d     = base_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        spi_sent_d = 1'b0;
        spi_cmd_d  = spi_cmd_q;
        spi_out_d  = spi_out_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        if (op_active) begin
            case (phase_q)
                PhIssue: begin
                    spi_sent_d = 1'b1;
                    spi_cmd_d  = op_cmd;
                    spi_out_d  = op_byte;
                    phase_d    = PhSent;
                end
                PhSent:  phase_d = PhGap;
                PhGap:   phase_d = PhPoll;
                default: if (!spi_st_i[0]) phase_d = PhIssue;
            endcase
        end

        if (op_done && spi_st_i[1] && !in_tail) begin
            error_d = ErrSpi;
            state_d = StCsHi;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        arg_d   = sdhc_i ? lba_i : {lba_i[22:0], 9'd0};
                        base_d  = base_i;
                        busy_d  = 1'b1;
                        error_d = ErrOk;
                        cnt_d   = '0;
                        phase_d = PhIssue;
                        state_d = StCsLo;
                    end
                end
                StCsLo: begin
                    if (op_done) begin
                        cnt_d   = '0;
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    if (op_done) begin
                        if (cnt_q == 13'd5) begin
                            cnt_d   = '0;
                            state_d = StR1;
                        end else begin
                            cnt_d = cnt_q + 13'd1;
                        end
                    end
                end
                StR1: begin
                    if (op_done) begin
                        if (spi_din_i == 8'hFF) begin
                            if (cnt_q < R1Max) begin
                                cnt_d = cnt_q + 13'd1;
                            end else begin
                                error_d = ErrR1Tmo;
                                state_d = StCsHi;
                            end
                        end else if (spi_din_i == 8'h00) begin
                            cnt_d   = '0;
                            state_d = StToken;
                        end else begin
                            error_d = ErrR1Bad;
                            state_d = StCsHi;
                        end
                    end
                end
                StToken: begin
                    if (op_done) begin
                        if (spi_din_i == 8'hFE) begin
                            cnt_d   = '0;
                            state_d = StData;
                        end else if (spi_din_i == 8'hFF) begin
                            if (cnt_q < TokMax) begin
                                cnt_d = cnt_q + 13'd1;
                            end else begin
                                error_d = ErrTokTmo;
                                state_d = StCsHi;
                            end
                        end else begin
                            error_d = ErrTokBad;
                            state_d = StCsHi;
                        end
                    end
                end
                StData: begin
                    if (op_done) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = base_q + {7'd0, cnt_q[8:0]};
                        mem_data_d = spi_din_i;
                        state_d    = StMemWr;
                    end
                end
                StMemWr: begin
                    // The next SPI op waits here until the RAM write has been accepted.
                    if (mem_gnt_i) begin
                        mem_req_d = 1'b0;
                        if (cnt_q[8:0] == 9'd511) begin
                            cnt_d   = '0;
                            state_d = StCrc;
                        end else begin
                            cnt_d   = cnt_q + 13'd1;
                            state_d = StData;
                        end
                    end
                end
                StCrc: begin
                    if (op_done) begin
                        if (cnt_q == 13'd1) begin
                            state_d = StCsHi;
                        end else begin
                            cnt_d = cnt_q + 13'd1;
                        end
                    end
                end
                StCsHi: begin
                    if (op_done) begin
                        if (spi_st_i[1] && (error_q == ErrOk)) error_d = ErrSpi;
                        state_d = StTrail;
                    end
                end
                StTrail: begin
                    if (op_done) begin
                        if (spi_st_i[1] && (error_q == ErrOk)) error_d = ErrSpi;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StFin;
                    end
                end
                StFin:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            phase_q    <= PhIssue;
            cnt_q      <= '0;
            arg_q      <= '0;
            base_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= ErrOk;
            spi_sent_q <= 1'b0;
            spi_cmd_q  <= CmdXfer;
            spi_out_q  <= 8'hFF;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            arg_q      <= arg_d;
            base_q     <= base_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            spi_sent_q <= spi_sent_d;
            spi_cmd_q  <= spi_cmd_d;
            spi_out_q  <= spi_out_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign spi_sent_o = spi_sent_q;
    assign spi_cmd_o  = spi_cmd_q;
    assign spi_out_o  = spi_out_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;

endmodule
